wb_queue: RTL and testbench

Write-back queue in front of the dual-write-port register file RAM. It collects completed results from two producers (ALU and load unit) through valid/ready handshakes and buffers them in a small in-order FIFO. Each cycle it drains up to two entries onto the RAM's A and B write ports, resolving same-address collisions. It can optionally zero the whole register file after reset.

---
 rtl/wb_queue.sv | 148 ++++++++++++++
 tb/tb_wb_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// wb_queue: in-order write-back FIFO that drains up to two results per cycle into the register file.
// Define WBQ_CLEAR_EN to add a post-reset sweep that zeroes every register.
//
// state    | meaning
// ST_CLEAR | zeroing sweep, two registers per cycle; producers held off
// ST_RUN   | accept results and drain oldest-first onto ports A/B
module wb_queue #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   p0_valid,
  input  logic [AWIDTH-1:0]      p0_addr,
  input  logic [DWIDTH-1:0]      p0_data,
  output logic                   p0_ready,
  input  logic                   p1_valid,
  input  logic [AWIDTH-1:0]      p1_addr,
  input  logic [DWIDTH-1:0]      p1_data,
  output logic                   p1_ready,
  input  logic                   stall,
  output logic [AWIDTH-1:0]      a_waddr,
  output logic [DWIDTH-1:0]      a_wdata,
  output logic                   a_we,
  output logic [AWIDTH-1:0]      b_waddr,
  output logic [DWIDTH-1:0]      b_wdata,
  output logic                   b_we,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  state_t state, state_next;

  logic [AWIDTH-1:0] mem_addr [DEPTH];
  logic [DWIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
  logic [CW-1:0]     free, pop_n, count_next;
  logic              run, enq0, enq1, pop1, pop2, sweep_on;
  logic [AWIDTH-1:0] sweep_addr;

  logic              a_we_q, b_we_q;
  logic [AWIDTH-1:0] a_waddr_q, b_waddr_q;
  logic [DWIDTH-1:0] a_wdata_q, b_wdata_q;

`ifdef WBQ_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
  localparam int     SWEEP_LAST  = 2**(AWIDTH-1) - 1;
  logic [AWIDTH-1:0] sweep_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != ST_CLEAR) sweep_cnt <= '0;
    else                            sweep_cnt <= sweep_cnt + AWIDTH'(1);
  end

  assign sweep_addr = AWIDTH'({sweep_cnt, 1'b0});
`else
  localparam state_t RESET_STATE = ST_RUN;
  assign sweep_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
`ifdef WBQ_CLEAR_EN
    if (state == ST_CLEAR && sweep_cnt == AWIDTH'(SWEEP_LAST)) state_next = ST_RUN;
`else
    state_next = ST_RUN;
`endif
  end

  // Readies see only the registered occupancy; a pop in the same cycle frees nothing yet.
  assign run        = (state == ST_RUN) && !reset;
  assign free       = CW'(DEPTH) - count;
  assign p0_ready   = run && (free >= CW'(1));
  assign p1_ready   = run && ((free >= CW'(2)) || (free == CW'(1) && !p0_valid));
  assign enq0       = p0_valid && p0_ready;
  assign enq1       = p1_valid && p1_ready;
  assign pop2       = run && !stall && (count >= CW'(2));
  assign pop1       = run && !stall && (count == CW'(1));
  assign pop_n      = pop2 ? CW'(2) : (pop1 ? CW'(1) : '0);
  assign count_next = count + CW'(enq0) + CW'(enq1) - pop_n;
  assign wr_ptr1    = wr_ptr + PW'(enq0);
  assign rd_ptr1    = rd_ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (enq0) begin
      mem_addr[wr_ptr] <= p0_addr;
      mem_data[wr_ptr] <= p0_data;
    end
    if (enq1) begin
      mem_addr[wr_ptr1] <= p1_addr;
      mem_data[wr_ptr1] <= p1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      a_we_q    <= 1'b0;
      b_we_q    <= 1'b0;
      a_waddr_q <= '0;
      b_waddr_q <= '0;
      a_wdata_q <= '0;
      b_wdata_q <= '0;
    end else begin
      wr_ptr <= wr_ptr1 + PW'(enq1);
      rd_ptr <= rd_ptr + pop_n[PW-1:0];
      count  <= count_next;
      a_we_q <= 1'b0;
      b_we_q <= 1'b0;
      if (pop2) begin
        // Same-address pair: only the newer entry (port B) may land.
        a_we_q    <= (mem_addr[rd_ptr] != mem_addr[rd_ptr1]);
        a_waddr_q <= mem_addr[rd_ptr];
        a_wdata_q <= mem_data[rd_ptr];
        b_we_q    <= 1'b1;
        b_waddr_q <= mem_addr[rd_ptr1];
        b_wdata_q <= mem_data[rd_ptr1];
      end else if (pop1) begin
        a_we_q    <= 1'b1;
        a_waddr_q <= mem_addr[rd_ptr];
        a_wdata_q <= mem_data[rd_ptr];
      end
    end
  end

  assign sweep_on = (state == ST_CLEAR) && !reset;

  assign a_we    = sweep_on || (a_we_q && !reset);
  assign b_we    = sweep_on || (b_we_q && !reset);
  assign a_waddr = reset ? '0 : (sweep_on ? sweep_addr : a_waddr_q);
  assign b_waddr = reset ? '0 : (sweep_on ? (sweep_addr | AWIDTH'(1)) : b_waddr_q);
  assign a_wdata = (reset || sweep_on) ? '0 : a_wdata_q;
  assign b_wdata = (reset || sweep_on) ? '0 : b_wdata_q;
  assign busy    = sweep_on || (!reset && count != '0);

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed vector table, reset/sweep sequences,
// then randomized traffic against a queue-level reference model.
module tb_wb_queue;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int DEP = 4;
  localparam int CW  = 3;
  localparam int NV  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_valid, p1_valid, p0_ready, p1_ready, stall;
  logic [AW-1:0] p0_addr, p1_addr, a_waddr, b_waddr;
  logic [DW-1:0] p0_data, p1_data, a_wdata, b_wdata;
  logic          a_we, b_we, busy;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  wb_queue #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_data(p1_data), .p1_ready(p1_ready),
    .stall(stall),
    .a_waddr(a_waddr), .a_wdata(a_wdata), .a_we(a_we),
    .b_waddr(b_waddr), .b_wdata(b_wdata), .b_we(b_we),
    .count(count), .busy(busy)
  );

  typedef struct {
    logic          p0v;
    logic [AW-1:0] p0a;
    logic [DW-1:0] p0d;
    logic          p1v;
    logic [AW-1:0] p1a;
    logic [DW-1:0] p1d;
    logic          st;
    logic          r0, r1;
    logic          awe;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          bwe;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    int            cnt;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vt [NV];
  ent_t q [$];

  function automatic vec_t mk(int p0v, int p0a, int p0d, int p1v, int p1a, int p1d, int st,
                              int r0, int r1, int awe, int aa, int ad, int bwe, int ba, int bd,
                              int cnt);
    vec_t r;
    r.p0v = (p0v != 0); r.p0a = AW'(p0a); r.p0d = DW'(p0d);
    r.p1v = (p1v != 0); r.p1a = AW'(p1a); r.p1d = DW'(p1d);
    r.st  = (st != 0);  r.r0  = (r0 != 0); r.r1  = (r1 != 0);
    r.awe = (awe != 0); r.aa  = AW'(aa);   r.ad  = DW'(ad);
    r.bwe = (bwe != 0); r.ba  = AW'(ba);   r.bd  = DW'(bd);
    r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic st);
    p0_valid = v0; p0_addr = a0; p0_data = d0;
    p1_valid = v1; p1_addr = a1; p1_data = d1;
    stall    = st;
  endtask

  task automatic chk_outs(input logic awe, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                          input logic bwe, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                          input int cnt);
    chk("a_we", 64'(a_we), 64'(awe));
    chk("b_we", 64'(b_we), 64'(bwe));
    if (awe) begin
      chk("a_waddr", 64'(a_waddr), 64'(aa));
      chk("a_wdata", 64'(a_wdata), 64'(ad));
    end
    if (bwe) begin
      chk("b_waddr", 64'(b_waddr), 64'(ba));
      chk("b_wdata", 64'(b_wdata), 64'(bd));
    end
    chk("count", 64'(count), 64'(cnt));
    chk("busy", 64'(busy), 64'(cnt != 0));
  endtask

  // Called at the sync point (one unit after a rising edge) right after reset drops.
  task automatic after_reset_release();
`ifdef WBQ_CLEAR_EN
    for (int k = 0; k < 2**(AW-1); k++) begin
      #1;
      chk("sweep_a_we", 64'(a_we), 64'(1));
      chk("sweep_b_we", 64'(b_we), 64'(1));
      chk("sweep_a_waddr", 64'(a_waddr), 64'(2*k));
      chk("sweep_b_waddr", 64'(b_waddr), 64'(2*k+1));
      chk("sweep_data", 64'({a_wdata, b_wdata}), 64'(0));
      chk("sweep_readies", 64'({p0_ready, p1_ready}), 64'(0));
      chk("sweep_busy", 64'(busy), 64'(1));
      @(posedge clk); #1;
    end
`endif
    #1;
    chk("run_p0_ready", 64'(p0_ready), 64'(1));
    chk("run_p1_ready", 64'(p1_ready), 64'(1));
    chk("run_busy", 64'(busy), 64'(0));
    chk("run_we", 64'({a_we, b_we}), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(1, 3, 'h1234, 0, 0, 0,    0, 1, 1, 0, 0, 0,      0, 0, 0,    1);
    vt[1]  = mk(0, 0, 0,      0, 0, 0,    0, 1, 1, 1, 3, 'h1234, 0, 0, 0,    0);
    vt[2]  = mk(1, 5, 'hAA,   1, 5, 'hBB, 0, 1, 1, 0, 0, 0,      0, 0, 0,    2);
    vt[3]  = mk(0, 0, 0,      0, 0, 0,    0, 1, 1, 0, 0, 0,      1, 5, 'hBB, 0);
    vt[4]  = mk(1, 1, 'h11,   1, 2, 'h22, 1, 1, 1, 0, 0, 0,      0, 0, 0,    2);
    vt[5]  = mk(1, 3, 'h33,   1, 4, 'h44, 1, 1, 1, 0, 0, 0,      0, 0, 0,    4);
    vt[6]  = mk(1, 6, 'h66,   1, 7, 'h77, 1, 0, 0, 0, 0, 0,      0, 0, 0,    4);
    vt[7]  = mk(0, 0, 0,      0, 0, 0,    0, 0, 0, 1, 1, 'h11,   1, 2, 'h22, 2);
    vt[8]  = mk(0, 0, 0,      0, 0, 0,    0, 1, 1, 1, 3, 'h33,   1, 4, 'h44, 0);
    vt[9]  = mk(1, 8, 'h80,   1, 9, 'h90, 1, 1, 1, 0, 0, 0,      0, 0, 0,    2);
    vt[10] = mk(1, 10, 'hA0,  0, 0, 0,    1, 1, 1, 0, 0, 0,      0, 0, 0,    3);
    vt[11] = mk(1, 11, 'hB0,  1, 12,'hC0, 1, 1, 0, 0, 0, 0,      0, 0, 0,    4);
    vt[12] = mk(0, 0, 0,      1, 12,'hC0, 1, 0, 0, 0, 0, 0,      0, 0, 0,    4);
    vt[13] = mk(0, 0, 0,      0, 0, 0,    0, 0, 0, 1, 8, 'h80,   1, 9, 'h90, 2);
    vt[14] = mk(0, 0, 0,      0, 0, 0,    0, 1, 1, 1, 10,'hA0,   1, 11,'hB0, 0);
    vt[15] = mk(0, 0, 0,      0, 0, 0,    0, 1, 1, 0, 0, 0,      0, 0, 0,    0);

    reset = 1'b1;
    drive(0, '0, '0, 0, '0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'({a_we, b_we}), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_readies", 64'({p0_ready, p1_ready}), 64'(0));
    chk("rst_addr", 64'({a_waddr, b_waddr}), 64'(0));
    reset = 1'b0;
    after_reset_release();

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].p0v, vt[i].p0a, vt[i].p0d, vt[i].p1v, vt[i].p1a, vt[i].p1d, vt[i].st);
      #1;
      chk("tbl_p0_ready", 64'(p0_ready), 64'(vt[i].r0));
      chk("tbl_p1_ready", 64'(p1_ready), 64'(vt[i].r1));
      @(posedge clk); #1;
      chk_outs(vt[i].awe, vt[i].aa, vt[i].ad, vt[i].bwe, vt[i].ba, vt[i].bd, vt[i].cnt);
    end

    // Three entries parked behind stall, then a one-cycle reset must discard them.
    drive(1, 4'd13, 32'hD1, 1, 4'd14, 32'hD2, 1);
    @(posedge clk); #1;
    drive(1, 4'd15, 32'hD3, 0, '0, '0, 1);
    @(posedge clk); #1;
    chk("park_count", 64'(count), 64'(3));
    drive(0, '0, '0, 0, '0, '0, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_we", 64'({a_we, b_we}), 64'(0));
    chk("mid_rst_count", 64'(count), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_readies", 64'({p0_ready, p1_ready}), 64'(0));
    reset = 1'b0;
    stall = 1'b0;
    after_reset_release();
    for (int i = 0; i < 6; i++) begin
      chk("discard_a_we", 64'(a_we), 64'(0));
      chk("discard_b_we", 64'(b_we), 64'(0));
      chk("discard_count", 64'(count), 64'(0));
      @(posedge clk); #1;
    end

    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic v0, v1, st, er0, er1, ea, eb;
      ent_t e0, e1, ia, ib;
      int   fr;
      v0   = ($urandom_range(0, 3) != 0);
      v1   = ($urandom_range(0, 3) != 0);
      st   = ($urandom_range(0, 3) == 0);
      e0.a = AW'($urandom_range(0, 3));
      e0.d = $urandom();
      e1.a = AW'($urandom_range(0, 3));
      e1.d = $urandom();
      ia   = '{default: '0};
      ib   = '{default: '0};
      drive(v0, e0.a, e0.d, v1, e1.a, e1.d, st);
      fr  = DEP - q.size();
      er0 = (fr >= 1);
      er1 = (fr >= 2) || (fr == 1 && !v0);
      #1;
      chk("rnd_p0_ready", 64'(p0_ready), 64'(er0));
      chk("rnd_p1_ready", 64'(p1_ready), 64'(er1));
      ea = 1'b0;
      eb = 1'b0;
      if (!st && q.size() >= 2) begin
        ia = q.pop_front();
        ib = q.pop_front();
        eb = 1'b1;
        ea = (ia.a != ib.a);
      end else if (!st && q.size() == 1) begin
        ia = q.pop_front();
        ea = 1'b1;
      end
      if (v0 && er0) q.push_back(e0);
      if (v1 && er1) q.push_back(e1);
      @(posedge clk); #1;
      chk_outs(ea, ia.a, ia.d, eb, ib.a, ib.d, q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
